reg_file_lrstack: RTL and testbench
===================================

Name: reg_file_lrstack

Overview:
Parametrised successor to the 8-bit CPU register file. It holds NREGS general registers of WIDTH bits, with two combinational read ports, one independently addressed write port with write-to-read bypass, and separately enabled N/Z condition flags. The single link register becomes a LR_DEPTH-entry hardware link stack with push/pop, depth count and sticky error flags, so subroutine calls can nest. It sits between the decoder/ALU writeback and the branch/call unit.

Parameters:
WIDTH, 8, data width of registers, write data and link entries
NREGS, 4, number of general registers (power of 2, >= 2)
LR_DEPTH, 4, link stack entries (>= 1)
ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes
(derived localparams: AW = clog2(NREGS); DW = clog2(LR_DEPTH+1))

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ra_addr  in  AW  read port A address
rb_addr  in  AW  read port B address
wr_addr  in  AW  write port address
wr_data  in  WIDTH  write data
wr_en  in  1  register write enable
n_in  in  1  new N flag value
z_in  in  1  new Z flag value
n_we  in  1  N flag write enable
z_we  in  1  Z flag write enable
ra_val  out  WIDTH  read data A (combinational, bypassed)
rb_val  out  WIDTH  read data B (combinational, bypassed)
n  out  1  N flag (registered)
z  out  1  Z flag (registered)
lr_in  in  WIDTH  return address to push
lr_push  in  1  push request
lr_pop  in  1  pop request
lr_out  out  WIDTH  top-of-stack value; 0 when empty
lr_depth  out  DW  number of valid stack entries
lr_overflow  out  1  sticky: push rejected while full
lr_underflow  out  1  sticky: pop rejected while empty

Behaviour:
- Reset (reset=1 at rising clk): all registers 0, n=z=0, lr_depth=0, all stack entries 0, lr_overflow=lr_underflow=0. Reset overrides every other input in that cycle. Reset mid-push/pop leaves the stack empty.
- Register write: on rising clk, if wr_en, reg[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Reads are combinational. Bypass: if wr_en and wr_addr==ra_addr, ra_val=wr_data in the same cycle, otherwise ra_val=reg[ra_addr]. rb_val follows the same rule. ZERO_REG=1 with address 0 always reads 0, with or without bypass. Both ports may read the same address.
- Flags: on rising clk, n<=n_in if n_we and z<=z_in if z_we. Each flag is independent. Flags have no bypass; a new value is visible the cycle after the write.
- Link stack: entries stk[0..LR_DEPTH-1]. lr_out = stk[lr_depth-1] when lr_depth>0, else 0 (combinational from registered state).
  - push only, depth<LR_DEPTH: stk[depth]<=lr_in, depth+1.
  - push only, depth==LR_DEPTH: no change to entries or depth; lr_overflow<=1.
  - pop only, depth>0: depth-1; the entry value is not cleared.
  - pop only, depth==0: no change; lr_underflow<=1.
  - push+pop, depth>0: top entry replaced with lr_in, depth unchanged, no error (tail-call swap).
  - push+pop, depth==0: treated as push only, no underflow.
- Sticky flags clear only on reset.
- Stack and register file operate independently; all operations may occur in the same cycle.

Test Plan:
- Reset, then write 0xA5 to r2. In the same cycle ra_addr=2 gives ra_val=0xA5 through the bypass; next cycle with wr_en=0 still gives 0xA5; r1 reads 0x00.
- ZERO_REG=1: write 0xFF to r0, then read r0 on both ports -> 0x00 in the write cycle and the next cycle.
- n_we=1, z_we=0, n_in=1, z_in=1 -> next cycle n=1, z=0. Then z_we=1, z_in=1 -> z=1, n holds 1.
- Push 0x10, 0x20, 0x30, 0x40 (LR_DEPTH=4) -> lr_depth=4, lr_out=0x40. Push 0x50 -> lr_overflow=1, lr_out stays 0x40. Pop x4 -> lr_out goes 0x30, 0x20, 0x10, then 0, with lr_depth=0.
- On an empty stack, pop -> lr_underflow=1, depth 0. Then push+pop with lr_in=0x77 -> depth 1, lr_out=0x77. Then push+pop with 0x88 -> depth 1, lr_out=0x88.
- With depth 3 and both sticky flags set, assert reset with lr_push=1 -> next cycle depth=0, lr_out=0, both sticky flags 0, all registers 0.

Source files
------------

// File: rtl/reg_file_lrstack.sv
// Parametrised CPU register file: NREGS x WIDTH registers, two bypassed read ports,
// N/Z flags, and a LR_DEPTH-entry link stack with sticky overflow/underflow flags.
module reg_file_lrstack #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NREGS    = 4,
    parameter int unsigned LR_DEPTH = 4,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [$clog2(NREGS)-1:0]           ra_addr,
    input  logic [$clog2(NREGS)-1:0]           rb_addr,
    input  logic [$clog2(NREGS)-1:0]           wr_addr,
    input  logic [WIDTH-1:0]                   wr_data,
    input  logic                               wr_en,
    input  logic                               n_in,
    input  logic                               z_in,
    input  logic                               n_we,
    input  logic                               z_we,
    output logic [WIDTH-1:0]                   ra_val,
    output logic [WIDTH-1:0]                   rb_val,
    output logic                               n,
    output logic                               z,
    input  logic [WIDTH-1:0]                   lr_in,
    input  logic                               lr_push,
    input  logic                               lr_pop,
    output logic [WIDTH-1:0]                   lr_out,
    output logic [$clog2(LR_DEPTH+1)-1:0]      lr_depth,
    output logic                               lr_overflow,
    output logic                               lr_underflow
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned DW = $clog2(LR_DEPTH + 1);
    localparam int unsigned SW = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;
    localparam logic [DW-1:0] MaxDepth = DW'(LR_DEPTH);
    localparam logic [DW-1:0] OneDepth = DW'(1);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             n_q, n_d;
    logic             z_q, z_d;

    logic [WIDTH-1:0] stk_q [LR_DEPTH];
    logic [WIDTH-1:0] stk_d [LR_DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic [SW-1:0]    top_idx;
    logic [SW-1:0]    free_idx;
    logic             wr_drop;

    assign top_idx  = SW'(depth_q - OneDepth);
    assign free_idx = SW'(depth_q);
    assign wr_drop  = ZERO_REG && (wr_addr == '0);

    // Register file and flags next state
    always_comb begin
        regs_d = regs_q;
        n_d    = n_q;
        z_d    = z_q;
        if (wr_en && !wr_drop) begin
            regs_d[wr_addr] = wr_data;
        end
        if (n_we) begin
            n_d = n_in;
        end
        if (z_we) begin
            z_d = z_in;
        end
    end

    // Read ports with same-cycle write bypass; a hardwired zero register wins over bypass
    always_comb begin
        ra_val = regs_q[ra_addr];
        if (wr_en && (wr_addr == ra_addr)) begin
            ra_val = wr_data;
        end
        if (ZERO_REG && (ra_addr == '0)) begin
            ra_val = '0;
        end

        rb_val = regs_q[rb_addr];
        if (wr_en && (wr_addr == rb_addr)) begin
            rb_val = wr_data;
        end
        if (ZERO_REG && (rb_addr == '0)) begin
            rb_val = '0;
        end
    end

    // Link stack next state
    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (lr_push && lr_pop) begin
            // Tail-call swap; on an empty stack it degrades to a plain push
            if (depth_q != '0) begin
                stk_d[top_idx] = lr_in;
            end else begin
                stk_d[0] = lr_in;
                depth_d  = OneDepth;
            end
        end else if (lr_push) begin
            if (depth_q < MaxDepth) begin
                stk_d[free_idx] = lr_in;
                depth_d         = depth_q + OneDepth;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (lr_pop) begin
            if (depth_q != '0) begin
                depth_d = depth_q - OneDepth;
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < LR_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            stk_q   <= stk_d;
            n_q     <= n_d;
            z_q     <= z_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign n            = n_q;
    assign z            = z_q;
    assign lr_out       = (depth_q != '0) ? stk_q[top_idx] : '0;
    assign lr_depth     = depth_q;
    assign lr_overflow  = ovf_q;
    assign lr_underflow = udf_q;

endmodule

// File: tb/tb_reg_file_lrstack.sv
// Bench for reg_file_lrstack: directed plan steps then random traffic, checked against a
// queue/array model; drives a ZERO_REG=0 and a ZERO_REG=1 instance in parallel.
module tb_reg_file_lrstack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREGS = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [1:0] ra_addr, rb_addr, wr_addr;
    logic [7:0] wr_data, lr_in;
    logic       wr_en, n_in, z_in, n_we, z_we, lr_push, lr_pop;

    logic [7:0] ra_val_a, rb_val_a, lr_out_a;
    logic [7:0] ra_val_b, rb_val_b, lr_out_b;
    logic [2:0] depth_a, depth_b;
    logic       n_a, z_a, ovf_a, udf_a;
    logic       n_b, z_b, ovf_b, udf_b;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0] m_regs_a [NREGS];
    logic [7:0] m_regs_b [NREGS];
    logic       m_n, m_z, m_ovf, m_udf;
    logic [7:0] m_stk [$];

    reg_file_lrstack #(.WIDTH(WIDTH), .NREGS(NREGS), .LR_DEPTH(DEPTH), .ZERO_REG(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .n_in(n_in), .z_in(z_in), .n_we(n_we), .z_we(z_we),
        .ra_val(ra_val_a), .rb_val(rb_val_a), .n(n_a), .z(z_a), .lr_in(lr_in),
        .lr_push(lr_push), .lr_pop(lr_pop), .lr_out(lr_out_a), .lr_depth(depth_a),
        .lr_overflow(ovf_a), .lr_underflow(udf_a)
    );

    reg_file_lrstack #(.WIDTH(WIDTH), .NREGS(NREGS), .LR_DEPTH(DEPTH), .ZERO_REG(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .n_in(n_in), .z_in(z_in), .n_we(n_we), .z_we(z_we),
        .ra_val(ra_val_b), .rb_val(rb_val_b), .n(n_b), .z(z_b), .lr_in(lr_in),
        .lr_push(lr_push), .lr_pop(lr_pop), .lr_out(lr_out_b), .lr_depth(depth_b),
        .lr_overflow(ovf_b), .lr_underflow(udf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [1:0] addr, input bit zero);
        if (zero && addr == 2'd0) return 8'h00;
        if (wr_en && wr_addr == addr) return wr_data;
        return zero ? m_regs_b[addr] : m_regs_a[addr];
    endfunction

    function automatic logic [7:0] exp_top();
        if (m_stk.size() == 0) return 8'h00;
        return m_stk[m_stk.size() - 1];
    endfunction

    task automatic check_all(input string ph);
        check({ph, ".ra_a"}, 32'(ra_val_a), 32'(exp_read(ra_addr, 1'b0)));
        check({ph, ".rb_a"}, 32'(rb_val_a), 32'(exp_read(rb_addr, 1'b0)));
        check({ph, ".ra_b"}, 32'(ra_val_b), 32'(exp_read(ra_addr, 1'b1)));
        check({ph, ".rb_b"}, 32'(rb_val_b), 32'(exp_read(rb_addr, 1'b1)));
        check({ph, ".n"}, 32'({n_a, n_b}), 32'({m_n, m_n}));
        check({ph, ".z"}, 32'({z_a, z_b}), 32'({m_z, m_z}));
        check({ph, ".lr_out"}, 32'({lr_out_a, lr_out_b}), 32'({exp_top(), exp_top()}));
        check({ph, ".depth"}, 32'({depth_a, depth_b}),
              32'({3'(m_stk.size()), 3'(m_stk.size())}));
        check({ph, ".ovf"}, 32'({ovf_a, ovf_b}), 32'({m_ovf, m_ovf}));
        check({ph, ".udf"}, 32'({udf_a, udf_b}), 32'({m_udf, m_udf}));
    endtask

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs_a[i] = 8'h00;
                m_regs_b[i] = 8'h00;
            end
            m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_stk.delete();
            return;
        end
        if (wr_en) begin
            m_regs_a[wr_addr] = wr_data;
            if (wr_addr != 2'd0) m_regs_b[wr_addr] = wr_data;
        end
        if (n_we) m_n = n_in;
        if (z_we) m_z = z_in;
        if (lr_push && lr_pop) begin
            if (m_stk.size() > 0) m_stk[m_stk.size() - 1] = lr_in;
            else m_stk.push_back(lr_in);
        end else if (lr_push) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(lr_in);
            else m_ovf = 1'b1;
        end else if (lr_pop) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    // Inputs are set by the caller; compare before and after the clock edge
    task automatic cycle();
        #2 check_all("pre");
        @(posedge clk);
        model_update();
        #1 check_all("post");
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; n_we = 0; z_we = 0; lr_push = 0; lr_pop = 0;
    endtask

    initial begin
        idle();
        ra_addr = 0; rb_addr = 0; wr_addr = 0; wr_data = 0; lr_in = 0; n_in = 0; z_in = 0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs_a[i] = 8'hxx;
            m_regs_b[i] = 8'hxx;
        end
        m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset
        reset = 1;
        @(posedge clk);
        model_update();
        #1 check_all("reset");
        idle();

        // Bypass of a write to r2, then registered value
        wr_en = 1; wr_addr = 2; wr_data = 8'hA5; ra_addr = 2; rb_addr = 1;
        #2 check("bypass_a5", 32'(ra_val_a), 32'h0000_00A5);
        cycle();
        wr_en = 0;
        #2 check("held_a5", 32'(ra_val_a), 32'h0000_00A5);
        check("r1_zero", 32'(rb_val_a), 32'h0);
        cycle();

        // Writes to r0: dropped on the zero-register instance
        wr_en = 1; wr_addr = 0; wr_data = 8'hFF; ra_addr = 0; rb_addr = 0;
        #2 check("zero_bypass", 32'({ra_val_b, rb_val_b}), 32'h0);
        cycle();
        wr_en = 0;
        #2 check("zero_after", 32'({ra_val_b, rb_val_b}), 32'h0);
        check("r0_plain", 32'(ra_val_a), 32'h0000_00FF);
        cycle();

        // Independent flag enables
        n_we = 1; z_we = 0; n_in = 1; z_in = 1;
        cycle();
        check("flag_n_only", 32'({n_a, z_a}), 32'b10);
        n_we = 0; z_we = 1;
        cycle();
        check("flag_z", 32'({n_a, z_a}), 32'b11);
        idle();

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) begin
            lr_push = 1; lr_in = 8'(i * 16);
            cycle();
        end
        check("full_top", 32'({depth_a, lr_out_a}), {21'h0, 3'd4, 8'h40});
        lr_in = 8'h50;
        cycle();
        check("overflow", 32'({ovf_a, lr_out_a}), {23'h0, 1'b1, 8'h40});
        lr_push = 0; lr_pop = 1;
        for (int i = 0; i < 4; i++) cycle();
        check("drained", 32'({depth_a, lr_out_a}), 32'h0);

        // Underflow then tail-call swaps
        cycle();
        check("underflow", 32'({udf_a, depth_a}), {28'h0, 1'b1, 3'd0});
        lr_push = 1; lr_in = 8'h77;
        cycle();
        check("swap_empty", 32'({depth_a, lr_out_a}), {21'h0, 3'd1, 8'h77});
        lr_in = 8'h88;
        cycle();
        check("swap_top", 32'({depth_a, lr_out_a, ovf_a, udf_a}), {19'h0, 3'd1, 8'h88, 2'b11});

        // Reset in the middle of a push with depth 3 and both sticky flags set
        lr_pop = 0; lr_in = 8'h99;
        cycle();
        lr_in = 8'hAA;
        cycle();
        check("depth3", 32'(depth_a), 32'd3);
        reset = 1; wr_en = 1; wr_addr = 3; wr_data = 8'h3C;
        cycle();
        check("reset_mid", 32'({depth_a, lr_out_a, ovf_a, udf_a}), 32'h0);
        idle();
        for (int a = 0; a < NREGS; a++) begin
            ra_addr = 2'(a);
            #1 check("reset_regs", 32'(ra_val_a), 32'h0);
        end
        cycle();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            reset   = ($urandom_range(0, 49) == 0);
            ra_addr = 2'($urandom_range(0, 3));
            rb_addr = 2'($urandom_range(0, 3));
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            wr_en   = 1'($urandom);
            n_in    = 1'($urandom);
            z_in    = 1'($urandom);
            n_we    = 1'($urandom);
            z_we    = 1'($urandom);
            lr_in   = 8'($urandom);
            lr_push = 1'($urandom);
            lr_pop  = 1'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
